uart_tx_feeder: RTL and testbench

- Buffered byte source placed directly upstream of the UART core's transmit port (data_in / wr_en / busy).
- Accepts bytes from the host in bursts into a synchronous FIFO.
- Drains the FIFO one byte at a time: issues a single-cycle write strobe to the transmitter, then waits until it reports not busy before sending the next byte.
- Host logic never has to track transmitter busy itself.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_feeder.sv | 103 ++++++++++
 tb/tb_uart_tx_feeder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side feeder.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int UART_BUSY_TMO = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] rdata_q;
  logic              push_ok, pop_ok;

  assign full    = (level_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem[rd_ptr_q];
      end
    end
  end

  assign rdata = rdata_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them to a UART transmitter one at a time,
// strobing wr_en and waiting out the transmitter's busy cycle.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DATA_W   = UART_DATA_W,
  parameter  int DEPTH    = 16,
  parameter  int BUSY_TMO = UART_BUSY_TMO,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              tmo_err,
  input  logic              err_clr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  output logic              idle
);

  localparam int CNT_W = $clog2(BUSY_TMO + 1);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;
  logic             pop, tmo_set, ovf_set;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (tx_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // A transmitter that never goes busy drops the byte rather than stalling.
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_set = push && full && !pop;
  assign ovf_d   = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
  assign tmo_d   = tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign tx_wr_en = (state_q == STROBE);
  assign ovf      = ovf_q;
  assign tmo_err  = tmo_q;
  assign idle     = empty && (state_q == IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter busy model.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst, push, err_clr, tx_busy;
  logic [7:0] push_data;
  logic       full, empty, ovf, tmo_err, tx_wr_en, idle;
  logic [4:0] level;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DATA_W(8), .DEPTH(16), .BUSY_TMO(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf),
    .tmo_err   (tmo_err),
    .err_clr   (err_clr),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .idle      (idle)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         strobes = 0;
  int         since = 1000;
  int         tmo_cyc = -1;
  int         push_cyc;
  int         n_before;
  bit         hold = 1'b0;
  bit         auto_busy = 1'b0;
  logic       tmo_prev = 1'b0;
  logic [7:0] rx_q[$];
  int         sc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, log strobes, then update the transmitter busy model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_wr_en) begin
      strobes++;
      rx_q.push_back(tx_data);
      sc_q.push_back(cyc);
      since = 0;
    end else if (since < 1000) begin
      since++;
    end
    if (tmo_err && !tmo_prev) tmo_cyc = cyc;
    tmo_prev = tmo_err;
    tx_busy = hold || (auto_busy && since >= 2 && since < 6);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    tick();
    push = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; push_data = '0; err_clr = 1'b0; tx_busy = 1'b0;

    // Reset state and quiet idle.
    repeat (3) tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tmo", tmo_err, 0);
    check("rst_wr_en", tx_wr_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_idle", idle, 1);
    rst = 1'b0;
    repeat (100) tick();
    check("quiet_strobes", strobes, 0);
    check("quiet_idle", idle, 1);

    // Single byte with a cooperating transmitter.
    auto_busy = 1'b1;
    rx_q.delete(); sc_q.delete();
    push_cyc = cyc;
    push_byte(8'hA5);
    repeat (20) tick();
    check("one_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      check("one_data", rx_q[0], 8'hA5);
      check("one_latency", sc_q[0] - push_cyc, 2);
    end
    check("one_held", tx_data, 8'hA5);
    check("one_idle", idle, 1);

    // Fill while busy, overflow, then drain in order.
    hold = 1'b1; tick();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_level", level, 16);
    check("fill_ovf", ovf, 0);
    push_byte(8'hFF);
    check("ovf_set", ovf, 1);
    check("ovf_level", level, 16);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    rx_q.delete();
    hold = 1'b0;
    for (int k = 0; k < 300 && !(rx_q.size() == 16 && idle); k++) tick();
    check("drain_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) check($sformatf("drain_%0d", i), rx_q[i], i);
    check("drain_idle", idle, 1);

    // Full FIFO: push and pop in the same cycle.
    hold = 1'b1; tick();
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check("pp_full", full, 1);
    hold = 1'b0; tx_busy = 1'b0;
    rx_q.delete();
    push_byte(8'h77);
    check("pp_level", level, 16);
    check("pp_ovf", ovf, 0);
    for (int k = 0; k < 300 && !(rx_q.size() == 17 && idle); k++) tick();
    check("pp_count", rx_q.size(), 17);
    if (rx_q.size() == 17) begin
      check("pp_first", rx_q[0], 8'h20);
      check("pp_mid", rx_q[15], 8'h2F);
      check("pp_last", rx_q[16], 8'h77);
    end

    // Transmitter never goes busy: timeout, then the next byte goes out.
    auto_busy = 1'b0;
    rx_q.delete(); sc_q.delete();
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (40) tick();
    check("tmo_count", rx_q.size(), 2);
    check("tmo_flag", tmo_err, 1);
    if (rx_q.size() == 2) begin
      check("tmo_data2", rx_q[1], 8'h22);
      check("tmo_when", tmo_cyc - sc_q[0], 8);
      check("tmo_next", sc_q[1] - sc_q[0], 9);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("tmo_clr", tmo_err, 0);

    // Asynchronous reset while waiting for busy to fall.
    auto_busy = 1'b1; hold = 1'b1; tick();
    for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i));
    hold = 1'b0;
    for (int k = 0; k < 50 && !(tx_busy && level == 5); k++) tick();
    check("mid_level", level, 5);
    check("mid_busy", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_wr_en", tx_wr_en, 0);
    check("arst_tx_data", tx_data, 0);
    n_before = strobes;
    repeat (2) tick();
    rst = 1'b0;
    repeat (50) tick();
    check("arst_no_strobe", strobes, n_before);
    check("arst_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
